// File: rtl/usrt_tx.sv
// USRT transmit stage: latches one APB byte per Tx select and shifts it out as a clocked serial frame.
// Latency: o_Pready one cycle after the accepting edge; start bit on the following edge when idle.
// Backpressure: while the holding register is full a Tx select waits with o_Pready low.
module usrt_tx #(
  parameter int CLKS_PER_HALF = 4,
  parameter int PARITY_EN     = 0,
  parameter int PARITY_ODD    = 0
) (
  input  logic       i_Pclk,
  input  logic       i_Preset_n,
  input  logic [1:0] i_Enable,
  input  logic [7:0] i_Pwdata,
  output logic       o_Pready,
  output logic       o_Sclk,
  output logic       o_Sdata,
  output logic       o_Busy
);

  localparam int CW = $clog2(CLKS_PER_HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_HALF - 1);
  localparam logic PAR_INIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [7:0]    r_hold;
  logic [7:0]    r_shift;
  logic          r_hold_full;
  logic          r_arm;
  logic          r_par;
  logic [2:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          r_sdata;
  logic          r_pready;

  wire w_tx_sel  = (i_Enable == 2'b11);
  // One byte per select assertion, and only into an empty holding register.
  wire w_accept  = w_tx_sel & r_arm & ~r_hold_full;
  // Last cycle of a bit: second half of the serial clock, counter at its top.
  wire w_bit_end = r_sclk & (r_cnt == CNT_LAST);

  // Write acceptance, serial-clock generation and the frame FSM.
  always_ff @(posedge i_Pclk or negedge i_Preset_n) begin
    if (!i_Preset_n) begin
      r_state     <= S_IDLE;
      r_hold      <= 8'h00;
      r_shift     <= 8'h00;
      r_hold_full <= 1'b0;
      r_arm       <= 1'b1;
      r_par       <= 1'b0;
      r_bit       <= 3'd0;
      r_cnt       <= '0;
      r_sclk      <= 1'b0;
      r_sdata     <= 1'b1;
      r_pready    <= 1'b0;
    end else begin
      r_pready <= w_accept;

      if (!w_tx_sel) begin
        r_arm <= 1'b1;
      end else if (w_accept) begin
        r_arm <= 1'b0;
      end

      // Acceptance needs an empty holder and loading needs a full one, so these never collide.
      if (w_accept) begin
        r_hold      <= i_Pwdata;
        r_hold_full <= 1'b1;
      end

      if (r_state != S_IDLE) begin
        if (r_cnt == CNT_LAST) begin
          r_cnt  <= '0;
          r_sclk <= ~r_sclk;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_sclk  <= 1'b0;
          r_sdata <= 1'b1;
          if (r_hold_full) begin
            r_state     <= S_START;
            r_shift     <= r_hold;
            r_par       <= (^r_hold) ^ PAR_INIT;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
            r_sdata     <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state <= S_DATA;
            r_bit   <= 3'd0;
            r_sdata <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              if (PARITY_EN != 0) begin
                r_state <= S_PARITY;
                r_sdata <= r_par;
              end else begin
                r_state <= S_STOP;
                r_sdata <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_sdata <= r_shift[0];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_sdata <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            // A byte already waiting goes straight into the next start bit with no idle gap.
            if (r_hold_full) begin
              r_state     <= S_START;
              r_shift     <= r_hold;
              r_par       <= (^r_hold) ^ PAR_INIT;
              r_hold_full <= 1'b0;
              r_cnt       <= '0;
              r_sclk      <= 1'b0;
              r_sdata     <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_sclk  <= 1'b0;
              r_sdata <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_Pready = r_pready;
  assign o_Sclk   = r_sclk;
  assign o_Sdata  = r_sdata;
  assign o_Busy   = (r_state != S_IDLE) | r_hold_full;

endmodule

// File: tb/tb_usrt_tx.sv
module tb_usrt_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] en = 2'b00;
  logic [7:0] data = 8'h00;

  logic pready0, sclk0, sdata0, busy0;
  logic pready1, sclk1, sdata1, busy1;
  logic pready2, sclk2, sdata2, busy2;

  always #5 clk = ~clk;

  usrt_tx #(.CLKS_PER_HALF(4), .PARITY_EN(0), .PARITY_ODD(0)) dut (
    .i_Pclk(clk), .i_Preset_n(rst_n), .i_Enable(en), .i_Pwdata(data),
    .o_Pready(pready0), .o_Sclk(sclk0), .o_Sdata(sdata0), .o_Busy(busy0));

  usrt_tx #(.CLKS_PER_HALF(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_pe (
    .i_Pclk(clk), .i_Preset_n(rst_n), .i_Enable(en), .i_Pwdata(data),
    .o_Pready(pready1), .o_Sclk(sclk1), .o_Sdata(sdata1), .o_Busy(busy1));

  usrt_tx #(.CLKS_PER_HALF(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_po (
    .i_Pclk(clk), .i_Preset_n(rst_n), .i_Enable(en), .i_Pwdata(data),
    .o_Pready(pready2), .o_Sclk(sclk2), .o_Sdata(sdata2), .o_Busy(busy2));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Which instance the per-cycle frame checker looks at.
  int sel = 0;
  logic m_sclk, m_sdata, m_busy, m_pready;
  always_comb begin
    m_sclk = sclk0; m_sdata = sdata0; m_busy = busy0; m_pready = pready0;
    case (sel)
      1: begin m_sclk = sclk1; m_sdata = sdata1; m_busy = busy1; m_pready = pready1; end
      2: begin m_sclk = sclk2; m_sdata = sdata2; m_busy = busy2; m_pready = pready2; end
      default: ;
    endcase
  end

  // Frame monitor on the default instance: samples o_Sdata at each o_Sclk rise.
  logic [7:0] rx_mem [0:63];
  int rx_wr = 0;
  int rx_bad = 0;
  int sclk_rises = 0;
  int mon_cnt = 0;
  logic [9:0] mon_bits = '0;
  logic prev_sclk = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_cnt = 0;
      prev_sclk = 1'b0;
    end else begin
      if (sclk0 && !prev_sclk) begin
        sclk_rises = sclk_rises + 1;
        mon_bits[mon_cnt] = sdata0;
        mon_cnt = mon_cnt + 1;
        if (mon_cnt == 10) begin
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) rx_bad = rx_bad + 1;
          rx_mem[rx_wr % 64] = mon_bits[8:1];
          rx_wr = rx_wr + 1;
          mon_cnt = 0;
        end
      end
      prev_sclk = sclk0;
    end
  end

  logic [7:0] exp_q[$];
  int rd_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rd_idx < rx_wr) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %0h expected none", rx_mem[rd_idx % 64]);
      end else begin
        e = exp_q.pop_front();
        chk("frame_byte", rx_mem[rd_idx % 64], e);
      end
      rd_idx++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy0 | busy1 | busy2) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy0 | busy1 | busy2) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
    end
  endtask

  // Called at the negedge after the start-bit edge; checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] d, input int nbits, input logic par, input int drop_k);
    logic [10:0] bits;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (nbits == 11) bits[9] = par;
    for (int k = 0; k < nbits * 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == drop_k) en = 2'b00;
      chk("frame_sdata", m_sdata, bits[k / 8]);
      chk("frame_sclk", m_sclk, ((k % 8) >= 4));
      chk("frame_busy", m_busy, 1);
      chk("no_second_pready", m_pready, 0);
    end
    @(negedge clk);
    chk("end_busy", m_busy, 0);
    chk("end_sdata", m_sdata, 1);
    chk("end_sclk", m_sclk, 0);
  endtask

  // From idle: assert a Tx write, check the pulse, and land on the negedge after the start edge.
  task automatic start_write(input logic [7:0] d);
    en = 2'b11;
    data = d;
    @(negedge clk);
    chk("pready_pulse", m_pready, 1);
    chk("busy_after_accept", m_busy, 1);
    chk("sdata_before_start", m_sdata, 1);
    @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] en;
    logic [7:0] d;
    logic       acc;
  } vec_t;
  vec_t tbl [7];

  initial begin
    int pc, bs, s, r0, n;

    tbl[0] = '{2'b11, 8'hA5, 1'b1};
    tbl[1] = '{2'b10, 8'hFF, 1'b0};
    tbl[2] = '{2'b11, 8'h00, 1'b1};
    tbl[3] = '{2'b11, 8'hFF, 1'b1};
    tbl[4] = '{2'b00, 8'h55, 1'b0};
    tbl[5] = '{2'b01, 8'hAA, 1'b0};
    tbl[6] = '{2'b11, 8'h80, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_pready", pready0, 0);
    chk("reset_sclk", sclk0, 0);
    chk("reset_sdata", sdata0, 1);
    chk("reset_busy", busy0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: each select code held 6 cycles, at most one acceptance.
    for (int i = 0; i < 7; i++) begin
      wait_idle(200);
      en = tbl[i].en;
      data = tbl[i].d;
      pc = 0;
      bs = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (pready0) pc++;
        if (busy0) bs = 1;
      end
      en = 2'b00;
      if (tbl[i].acc) exp_q.push_back(tbl[i].d);
      chk("tbl_pready_count", pc, tbl[i].acc);
      chk("tbl_busy_seen", bs, tbl[i].acc);
      wait_idle(200);
      repeat (2) @(negedge clk);
      drain();
    end

    // A5 cycle-exact, enable held 4 cycles past the ready pulse.
    sel = 0;
    @(negedge clk);
    start_write(8'hA5);
    exp_q.push_back(8'hA5);
    check_frame(8'hA5, 10, 1'b0, 3);
    repeat (2) @(negedge clk);
    drain();

    // Three writes: A5, 3C during frame 1, 0F pending until frame 1 stop->start.
    wait_idle(200);
    en = 2'b11;
    data = 8'hA5;
    @(negedge clk);
    chk("b2b_pready_a5", pready0, 1);
    exp_q.push_back(8'hA5);
    en = 2'b00;
    @(negedge clk);
    s = cyc;
    chk("b2b_start_sdata", sdata0, 0);
    r0 = sclk_rises;
    repeat (20) @(negedge clk);
    en = 2'b11;
    data = 8'h3C;
    @(negedge clk);
    chk("b2b_pready_3c", pready0, 1);
    exp_q.push_back(8'h3C);
    en = 2'b00;
    @(negedge clk);
    en = 2'b11;
    data = 8'h0F;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pready0 && n < 200);
    chk("b2b_pready_0f_cycle", cyc - s, 81);
    exp_q.push_back(8'h0F);
    en = 2'b00;
    n = 0;
    while (busy0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_length", cyc - s, 240);
    chk("b2b_rises", sclk_rises - r0, 30);
    repeat (2) @(negedge clk);
    drain();

    // Parity: even then odd on A5, 11-bit frames.
    wait_idle(300);
    @(negedge clk);
    sel = 1;
    start_write(8'hA5);
    exp_q.push_back(8'hA5);
    check_frame(8'hA5, 11, 1'b0, 3);
    wait_idle(300);
    @(negedge clk);
    sel = 2;
    start_write(8'hA5);
    exp_q.push_back(8'hA5);
    check_frame(8'hA5, 11, 1'b1, 3);
    sel = 0;
    repeat (2) @(negedge clk);
    drain();

    // Reset during data bit 3 with a second byte held.
    wait_idle(300);
    @(negedge clk);
    en = 2'b11;
    data = 8'hA5;
    @(negedge clk);
    chk("rst_pready_a5", pready0, 1);
    en = 2'b00;
    @(negedge clk);
    chk("rst_start_sdata", sdata0, 0);
    en = 2'b11;
    data = 8'h3C;
    @(negedge clk);
    chk("rst_held_accept", pready0, 1);
    en = 2'b00;
    repeat (37) @(negedge clk);
    chk("rst_pre_sdata", sdata0, 0);
    chk("rst_pre_sclk", sclk0, 1);
    chk("rst_pre_busy", busy0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sdata", sdata0, 1);
    chk("rst_async_sclk", sclk0, 0);
    chk("rst_async_busy", busy0, 0);
    chk("rst_async_pready", pready0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r0 = sclk_rises;
    bs = 0;
    repeat (150) begin
      @(negedge clk);
      if (busy0) bs = 1;
    end
    chk("post_reset_busy", bs, 0);
    chk("post_reset_rises", sclk_rises - r0, 0);
    start_write(8'h5A);
    exp_q.push_back(8'h5A);
    check_frame(8'h5A, 10, 1'b0, 3);
    repeat (2) @(negedge clk);
    drain();

    chk("exp_queue_empty", exp_q.size(), 0);
    chk("frame_format_errors", rx_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
